// File: rtl/mod6_seq_checker_if.sv
// Bus bundle for mod6_seq_checker: sampled count and clear in, checker status out.
// WRAP_W must match the checker instance's WRAP_W.
interface mod6_seq_checker_if #(
   parameter int unsigned WRAP_W = 8
);
   logic [2:0]        q;
   logic              clr;
   logic              wrap;
   logic [WRAP_W-1:0] wrap_cnt;
   logic              err;
   logic [1:0]        err_code;
   logic [1:0]        state;
   logic [2:0]        cur;

   modport master (
      output q, clr,
      input  wrap, wrap_cnt, err, err_code, state, cur
   );

   modport slave (
      input  q, clr,
      output wrap, wrap_cnt, err, err_code, state, cur
   );
endinterface

// File: rtl/mod6_seq_checker.sv
// Sequence checker for a mod-6 counter: tracks 0..5 with holds, counts wraps, latches faults.
// Define MOD6_CHK_SYNC_EN to insert a 2-flop input register in front of the FSM.
module mod6_seq_checker #(
   parameter int unsigned WRAP_W = 8
) (
   input logic               clk,
   input logic               rst,
   mod6_seq_checker_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StTrack = 2'b01,
      StError = 2'b10
   } state_e;

   localparam logic [1:0] CodeNone    = 2'b00;
   localparam logic [1:0] CodeIllegal = 2'b01;
   localparam logic [1:0] CodeBadStep = 2'b10;
   localparam logic [1:0] CodeBadInit = 2'b11;

   logic [2:0] s;

`ifdef MOD6_CHK_SYNC_EN
   logic [2:0] sync1_q;
   logic [2:0] sync2_q;

   // Not cleared by clr: only rst flushes the input pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 3'd0;
         sync2_q <= 3'd0;
      end else begin
         sync1_q <= bus.q;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   assign s = bus.q;
`endif

   state_e            state_q;
   logic [2:0]        cur_q;
   logic              wrap_q;
   logic [WRAP_W-1:0] wrap_cnt_q;
   logic              err_q;
   logic [1:0]        err_code_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cur_q      <= 3'd0;
         wrap_q     <= 1'b0;
         wrap_cnt_q <= '0;
         err_q      <= 1'b0;
         err_code_q <= CodeNone;
      end else if (bus.clr) begin
         state_q    <= StIdle;
         cur_q      <= 3'd0;
         wrap_q     <= 1'b0;
         wrap_cnt_q <= '0;
         err_q      <= 1'b0;
         err_code_q <= CodeNone;
      end else begin
         wrap_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (s == 3'd0) begin
                  state_q <= StTrack;
                  cur_q   <= 3'd0;
               end else begin
                  state_q    <= StError;
                  err_q      <= 1'b1;
                  err_code_q <= (s >= 3'd6) ? CodeIllegal : CodeBadInit;
               end
            end
            StTrack: begin
               if (s >= 3'd6) begin
                  state_q    <= StError;
                  err_q      <= 1'b1;
                  err_code_q <= CodeIllegal;
               end else if (s == cur_q) begin
                  // hold: nothing changes
               end else if ((cur_q < 3'd5) && (s == cur_q + 3'd1)) begin
                  cur_q <= s;
               end else if ((cur_q == 3'd5) && (s == 3'd0)) begin
                  cur_q      <= 3'd0;
                  wrap_q     <= 1'b1;
                  wrap_cnt_q <= wrap_cnt_q + WRAP_W'(1);
               end else begin
                  state_q    <= StError;
                  err_q      <= 1'b1;
                  err_code_q <= CodeBadStep;
               end
            end
            StError: begin
               // sticky until clr or rst
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.state    = state_q;
   assign bus.cur      = cur_q;
   assign bus.wrap     = wrap_q;
   assign bus.wrap_cnt = wrap_cnt_q;
   assign bus.err      = err_q;
   assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_mod6_seq_checker.sv
// Scoreboard bench for mod6_seq_checker (default build): directed vectors with hand-computed
// expectations; a second instance with WRAP_W=2 shares the stimulus to exercise rollover.
module tb_mod6_seq_checker;

   logic clk;
   logic rst;

   mod6_seq_checker_if #(.WRAP_W(8)) bus ();
   mod6_seq_checker_if #(.WRAP_W(2)) bus2 ();

   assign bus2.q   = bus.q;
   assign bus2.clr = bus.clr;

   mod6_seq_checker #(.WRAP_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   mod6_seq_checker #(.WRAP_W(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [1:0] I = 2'd0;
   localparam logic [1:0] T = 2'd1;
   localparam logic [1:0] E = 2'd2;

   typedef struct {
      string      tag;
      logic [1:0] st;
      logic [2:0] cur;
      logic       wrap;
      logic [7:0] cnt;
      logic [1:0] cnt2;
      logic       err;
      logic [1:0] code;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   done     = 1'b0;

   task automatic chk(input string tag, input string fld, input logic [7:0] act,
                      input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s.%s actual=%0h required=%0h (t=%0t)", tag, fld, act, req, $time);
      end
   endtask

   // Drive one vector at a negedge and queue the response expected after the next posedge.
   task automatic step(input string tag, input logic [2:0] qv, input logic clrv,
                       input logic [1:0] st, input logic [2:0] cur, input logic wrap,
                       input logic [7:0] cnt, input logic [1:0] cnt2, input logic err,
                       input logic [1:0] code);
      exp_t e;
      bus.q   = qv;
      bus.clr = clrv;
      e.tag = tag; e.st = st; e.cur = cur; e.wrap = wrap; e.cnt = cnt;
      e.cnt2 = cnt2; e.err = err; e.code = code;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic chk_reset(input string tag);
      chk(tag, "state", 8'(bus.state), 8'(I));
      chk(tag, "cur", 8'(bus.cur), 8'd0);
      chk(tag, "wrap", 8'(bus.wrap), 8'd0);
      chk(tag, "wrap_cnt", bus.wrap_cnt, 8'd0);
      chk(tag, "wrap_cnt2", 8'(bus2.wrap_cnt), 8'd0);
      chk(tag, "err", 8'(bus.err), 8'd0);
      chk(tag, "err_code", 8'(bus.err_code), 8'd0);
   endtask

   // Monitor: outputs are valid every cycle, so pop one expectation per clock when present.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, "state", 8'(bus.state), 8'(e.st));
            chk(e.tag, "cur", 8'(bus.cur), 8'(e.cur));
            chk(e.tag, "wrap", 8'(bus.wrap), 8'(e.wrap));
            chk(e.tag, "wrap_cnt", bus.wrap_cnt, e.cnt);
            chk(e.tag, "wrap_cnt2", 8'(bus2.wrap_cnt), 8'(e.cnt2));
            chk(e.tag, "err", 8'(bus.err), 8'(e.err));
            chk(e.tag, "err_code", 8'(bus.err_code), 8'(e.code));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst     = 1'b1;
      bus.q   = 3'd0;
      bus.clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;

      // Normal counting: 13 samples, two wraps.
      step("cnt0", 3'd0, 1'b0, T, 3'd0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      for (int v = 1; v <= 5; v++)
         step("cnt_a", 3'(v), 1'b0, T, 3'(v), 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      step("wrap1", 3'd0, 1'b0, T, 3'd0, 1'b1, 8'd1, 2'd1, 1'b0, 2'd0);
      for (int v = 1; v <= 5; v++)
         step("cnt_b", 3'(v), 1'b0, T, 3'(v), 1'b0, 8'd1, 2'd1, 1'b0, 2'd0);
      step("wrap2", 3'd0, 1'b0, T, 3'd0, 1'b1, 8'd2, 2'd2, 1'b0, 2'd0);

      // Hold at 2 for five clocks.
      step("hold1", 3'd1, 1'b0, T, 3'd1, 1'b0, 8'd2, 2'd2, 1'b0, 2'd0);
      step("hold2", 3'd2, 1'b0, T, 3'd2, 1'b0, 8'd2, 2'd2, 1'b0, 2'd0);
      repeat (5) step("holding", 3'd2, 1'b0, T, 3'd2, 1'b0, 8'd2, 2'd2, 1'b0, 2'd0);
      step("hold3", 3'd3, 1'b0, T, 3'd3, 1'b0, 8'd2, 2'd2, 1'b0, 2'd0);

      // Illegal code, then sticky under legal input.
      step("ill6", 3'd6, 1'b0, E, 3'd3, 1'b0, 8'd2, 2'd2, 1'b1, 2'd1);
      step("stick4", 3'd4, 1'b0, E, 3'd3, 1'b0, 8'd2, 2'd2, 1'b1, 2'd1);
      step("stick0", 3'd0, 1'b0, E, 3'd3, 1'b0, 8'd2, 2'd2, 1'b1, 2'd1);

      // clr out of ERROR, then skip 1->3.
      step("clr", 3'd0, 1'b1, I, 3'd0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      step("restart", 3'd0, 1'b0, T, 3'd0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      step("skip1", 3'd1, 1'b0, T, 3'd1, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      step("skip3", 3'd3, 1'b0, E, 3'd1, 1'b0, 8'd0, 2'd0, 1'b1, 2'd2);

      // Bad start after clr.
      step("clr2", 3'd0, 1'b1, I, 3'd0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      step("bad_st", 3'd1, 1'b0, E, 3'd0, 1'b0, 8'd0, 2'd0, 1'b1, 2'd3);

      // clr on the 5->0 cycle suppresses the wrap.
      step("clr3", 3'd0, 1'b1, I, 3'd0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      step("cw0", 3'd0, 1'b0, T, 3'd0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      for (int v = 1; v <= 5; v++)
         step("cw_run", 3'(v), 1'b0, T, 3'(v), 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      step("clr_wrap", 3'd0, 1'b1, I, 3'd0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      step("cw_trk", 3'd0, 1'b0, T, 3'd0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);

      // clr on a fault cycle suppresses the error.
      step("cf1", 3'd1, 1'b0, T, 3'd1, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      step("clr_flt", 3'd7, 1'b1, I, 3'd0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      step("cf_trk", 3'd0, 1'b0, T, 3'd0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);

      // Async reset mid-cycle with q=3.
      for (int v = 1; v <= 3; v++)
         step("pre_rst", 3'(v), 1'b0, T, 3'(v), 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      #2;
      rst = 1'b1;
      #1;
      chk_reset("async_rst");
      @(negedge clk);
      bus.q = 3'd4;
      @(negedge clk);
      rst = 1'b0;
      step("rst_bad4", 3'd4, 1'b0, E, 3'd0, 1'b0, 8'd0, 2'd0, 1'b1, 2'd3);

      // Five full cycles: 8-bit count reaches 5, 2-bit count rolls over to 1.
      step("clr4", 3'd0, 1'b1, I, 3'd0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      step("ro0", 3'd0, 1'b0, T, 3'd0, 1'b0, 8'd0, 2'd0, 1'b0, 2'd0);
      for (int c = 1; c <= 5; c++) begin
         for (int v = 1; v <= 5; v++)
            step("ro_run", 3'(v), 1'b0, T, 3'(v), 1'b0, 8'(c - 1), 2'(c - 1), 1'b0, 2'd0);
         step("ro_wrap", 3'd0, 1'b0, T, 3'd0, 1'b1, 8'(c), 2'(c), 1'b0, 2'd0);
      end
      step("ro_after", 3'd0, 1'b0, T, 3'd0, 1'b0, 8'd5, 2'd1, 1'b0, 2'd0);

      @(negedge clk);
      chk("end", "queue_left", 8'(exp_q.size()), 8'd0);
      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
